// File: rtl/super_stack.sv
// -----------------------------------------------------------------------------
// super_stack
//
// Synchronous LIFO operand/frame stack of WIDTH-bit words. Capacity is
// MAX_STACK = 2^(DEPTH+1)-1 entries, so the stack pointer fits in DEPTH+1 bits
// with the all-ones value meaning "full". The top three entries are presented
// on registered outputs.
//
// Frame support: underflow_limit marks the lowest entry owned by the current
// frame. POP/REPLACE refuse to cross it. UNDERFLOW_GET/SET address entries
// below it, counting downwards from underflow_limit-1, and are bounded by the
// caller-supplied window [lower_limit, upper_limit).
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-low reset
//   op               in   3-bit operation code (see OP_* below)
//   data             in   write data
//   offset           in   new index (INDEX_RESET*) or frame offset (UNDERFLOW_*)
//   underflow_limit  in   lowest index owned by the current frame
//   upper_limit      in   exclusive upper bound for UNDERFLOW_* addresses
//   lower_limit      in   inclusive lower bound for UNDERFLOW_* addresses
//   index            out  number of entries (stack pointer)
//   out/out1/out2    out  stack[index-1] / stack[index-2] / stack[index-3]
//   status           out  result of the op sampled at the previous edge
// -----------------------------------------------------------------------------
module super_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [DEPTH:0]   offset,
  input  logic [DEPTH:0]   underflow_limit,
  input  logic [DEPTH:0]   upper_limit,
  input  logic [DEPTH:0]   lower_limit,
  output logic [DEPTH:0]   index,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [2:0]       status
);

  localparam int IW      = DEPTH + 1;
  localparam int MAX_INT = (1 << IW) - 1;
  // Capacity equals the all-ones pointer value.
  localparam logic [IW-1:0] MAX_STACK = '1;

  // Operation codes
  localparam logic [2:0] OP_NONE        = 3'd0;
  localparam logic [2:0] OP_PUSH        = 3'd1;
  localparam logic [2:0] OP_POP         = 3'd2;
  localparam logic [2:0] OP_REPLACE     = 3'd3;
  localparam logic [2:0] OP_INDEX_RESET = 3'd4;
  localparam logic [2:0] OP_IDX_RST_PSH = 3'd5;
  localparam logic [2:0] OP_UF_GET      = 3'd6;
  localparam logic [2:0] OP_UF_SET      = 3'd7;

  // Status codes
  localparam logic [2:0] ST_NONE       = 3'd0;
  localparam logic [2:0] ST_EMPTY      = 3'd1;
  localparam logic [2:0] ST_FULL       = 3'd2;
  localparam logic [2:0] ST_OVERFLOW   = 3'd3;
  localparam logic [2:0] ST_UNDERFLOW  = 3'd4;
  localparam logic [2:0] ST_BAD_OFFSET = 3'd5;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [MAX_INT];
  logic [IW-1:0]    index_q, index_d;
  logic [2:0]       status_q, status_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;

  // Decoded control
  logic             we;        // memory write this cycle
  logic [IW-1:0]    waddr;     // memory write address
  logic             refresh;   // reload out/out1/out2 from the new top of stack
  logic             get_hit;   // valid UNDERFLOW_GET: load out from frame slot
  logic [IW-1:0]    uf_addr;   // frame slot address for UNDERFLOW_*
  logic             uf_valid;

  // Occupancy status of a pointer value relative to the frame base.
  function automatic logic [2:0] occ(input logic [IW-1:0] i,
                                     input logic [IW-1:0] ul);
    if (i < ul)              occ = ST_UNDERFLOW;
    else if (i == ul)        occ = ST_EMPTY;
    else if (i == MAX_STACK) occ = ST_FULL;
    else                     occ = ST_NONE;
  endfunction

  // Frame slots are numbered downwards from underflow_limit-1. The
  // offset < underflow_limit term also rules out a wrapped address.
  always_comb begin
    uf_addr  = underflow_limit - IW'(1) - offset;
    uf_valid = (offset < underflow_limit) &&
               (lower_limit <= uf_addr) && (uf_addr < upper_limit);
  end

  // ---------------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through the
  // case leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    index_d  = index_q;
    status_d = ST_NONE;
    we       = 1'b0;
    waddr    = index_q;
    refresh  = 1'b0;
    get_hit  = 1'b0;

    unique case (op)
      OP_NONE: begin
        status_d = occ(index_q, underflow_limit);
        refresh  = 1'b1;
      end

      OP_PUSH: begin
        if (index_q == MAX_STACK) begin
          status_d = ST_OVERFLOW;
        end else begin
          // Pushing below the frame base is legal; only POP/REPLACE guard it.
          we       = 1'b1;
          waddr    = index_q;
          index_d  = index_q + IW'(1);
          status_d = occ(index_d, underflow_limit);
          refresh  = 1'b1;
        end
      end

      OP_POP: begin
        if (index_q <= underflow_limit) begin
          status_d = ST_UNDERFLOW;
        end else begin
          index_d  = index_q - IW'(1);
          status_d = occ(index_d, underflow_limit);
          refresh  = 1'b1;
        end
      end

      OP_REPLACE: begin
        if (index_q <= underflow_limit) begin
          status_d = ST_UNDERFLOW;
        end else begin
          we       = 1'b1;
          waddr    = index_q - IW'(1);
          status_d = occ(index_q, underflow_limit);
          refresh  = 1'b1;
        end
      end

      OP_INDEX_RESET: begin
        // offset is IW bits wide, so it can never exceed MAX_STACK and the
        // BAD_OFFSET case is unreachable. Outputs deliberately keep their
        // old values here.
        index_d  = offset;
        status_d = occ(offset, underflow_limit);
      end

      OP_IDX_RST_PSH: begin
        if (offset == MAX_STACK) begin
          status_d = ST_OVERFLOW;
        end else begin
          // Performed even if the resulting pointer is below the frame base.
          we       = 1'b1;
          waddr    = offset;
          index_d  = offset + IW'(1);
          status_d = occ(index_d, underflow_limit);
          refresh  = 1'b1;
        end
      end

      OP_UF_GET: begin
        if (uf_valid) begin
          get_hit  = 1'b1;
          status_d = ST_NONE;
        end else begin
          status_d = ST_BAD_OFFSET;
        end
      end

      OP_UF_SET: begin
        if (uf_valid) begin
          we       = 1'b1;
          waddr    = uf_addr;
          status_d = ST_NONE;
        end else begin
          status_d = ST_BAD_OFFSET;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output refresh
  // ---------------------------------------------------------------------------
  // The three visible slots sit at index_d-1..index_d-3. A write in the same
  // cycle may land on one of them, so it is forwarded ahead of the array.
  logic [IW-1:0]    rd_addr [3];
  logic             rd_ok   [3];
  logic [WIDTH-1:0] rd_val  [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_ok[k]   = 32'(index_d) >= k + 1;
      rd_addr[k] = rd_ok[k] ? index_d - IW'(k + 1) : '0;
      rd_val[k]  = (we && waddr == rd_addr[k]) ? data : mem_q[rd_addr[k]];
    end
  end

  always_comb begin
    out_d  = out_q;
    out1_d = out1_q;
    out2_d = out2_q;
    // Slots that would fall below entry 0 keep their previous contents.
    if (refresh) begin
      if (rd_ok[0]) out_d  = rd_val[0];
      if (rd_ok[1]) out1_d = rd_val[1];
      if (rd_ok[2]) out2_d = rd_val[2];
    end
    if (get_hit) out_d = mem_q[uf_addr];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      index_q  <= '0;
      status_q <= ST_EMPTY;
      // out/out1/out2 intentionally keep their values through reset.
    end else begin
      index_q  <= index_d;
      status_q <= status_d;
      out_q    <= out_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
    end
  end

  // NOTE: the storage array has no reset; clearing index is enough to make it
  // logically empty, and leaving it unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (reset && we) mem_q[waddr] <= data;
  end

  assign index  = index_q;
  assign status = status_q;
  assign out    = out_q;
  assign out1   = out1_q;
  assign out2   = out2_q;

endmodule

// File: tb/tb_super_stack.sv
// -----------------------------------------------------------------------------
// tb_super_stack
//
// Scoreboard bench for super_stack. A driver applies one op per cycle on the
// falling edge and, from a queue/array reference model of the stack rules,
// pushes the expected registered response. A monitor pops one expectation
// after each rising edge and compares it against the DUT outputs. Output words
// whose source entry was never written are marked unknown and not compared.
// -----------------------------------------------------------------------------
module tb_super_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1;
  localparam int MAX   = 3;

  localparam logic [2:0] NONE = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3,
                         IRST = 3'd4, IRSTP = 3'd5, UGET = 3'd6, USET = 3'd7;
  localparam int S_NONE = 0, S_EMPTY = 1, S_FULL = 2, S_OVF = 3, S_UNF = 4,
                 S_BAD = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       op = NONE;
  logic [WIDTH-1:0] data = '0;
  logic [DEPTH:0]   offset = '0;
  logic [DEPTH:0]   underflow_limit = '0;
  logic [DEPTH:0]   upper_limit = '0;
  logic [DEPTH:0]   lower_limit = '0;
  logic [DEPTH:0]   index;
  logic [WIDTH-1:0] out, out1, out2;
  logic [2:0]       status;

  super_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .op              (op),
    .data            (data),
    .offset          (offset),
    .underflow_limit (underflow_limit),
    .upper_limit     (upper_limit),
    .lower_limit     (lower_limit),
    .index           (index),
    .out             (out),
    .out1            (out1),
    .out2            (out2),
    .status          (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    step;
    int                    idx;
    int                    st;
    logic [2:0][WIDTH-1:0] o;
    logic [2:0]            known;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0]      m_mem [MAX];
  bit                    m_known [MAX];
  int                    m_idx = 0;
  logic [2:0][WIDTH-1:0] m_out = '0;
  logic [2:0]            m_ok = '0;

  function automatic int occ(input int i, input int ulim);
    if (i < ulim)       return S_UNF;
    else if (i == ulim) return S_EMPTY;
    else if (i == MAX)  return S_FULL;
    return S_NONE;
  endfunction

  task automatic model_refresh(input int n);
    for (int k = 1; k <= 3; k++) begin
      if (n - k >= 0) begin
        m_out[k-1] = m_mem[n-k];
        m_ok[k-1]  = m_known[n-k];
      end
    end
  endtask

  task automatic model_write(input int a, input logic [WIDTH-1:0] d);
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endtask

  task automatic check(input string name, input int stp, input int act,
                       input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, stp, act, exp);
    end
  endtask

  // Drive one op (or a reset cycle), advance the model, queue the expectation.
  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input int off, input int ulim, input int upl,
                       input int lol, input bit rst_low);
    int   st;
    int   addr;
    bit   valid;
    exp_t e;
    @(negedge clk);
    reset           = ~rst_low;
    op              = o;
    data            = d;
    offset          = (DEPTH+1)'(off);
    underflow_limit = (DEPTH+1)'(ulim);
    upper_limit     = (DEPTH+1)'(upl);
    lower_limit     = (DEPTH+1)'(lol);

    st = S_NONE;
    if (rst_low) begin
      m_idx = 0;
      st    = S_EMPTY;
    end else begin
      case (o)
        NONE: begin
          st = occ(m_idx, ulim);
          model_refresh(m_idx);
        end
        PUSH: begin
          if (m_idx == MAX) st = S_OVF;
          else begin
            model_write(m_idx, d);
            m_idx++;
            st = occ(m_idx, ulim);
            model_refresh(m_idx);
          end
        end
        POP: begin
          if (m_idx <= ulim) st = S_UNF;
          else begin
            m_idx--;
            st = occ(m_idx, ulim);
            model_refresh(m_idx);
          end
        end
        REPLACE: begin
          if (m_idx <= ulim) st = S_UNF;
          else begin
            model_write(m_idx - 1, d);
            st = occ(m_idx, ulim);
            model_refresh(m_idx);
          end
        end
        IRST: begin
          if (off > MAX) st = S_BAD;
          else begin
            m_idx = off;
            st    = occ(off, ulim);
          end
        end
        IRSTP: begin
          if (off >= MAX) st = S_OVF;
          else begin
            model_write(off, d);
            m_idx = off + 1;
            st    = occ(m_idx, ulim);
            model_refresh(m_idx);
          end
        end
        default: begin // UGET / USET
          addr  = ulim - 1 - off;
          valid = (off < ulim) && (lol <= addr) && (addr < upl);
          if (!valid) st = S_BAD;
          else if (o == UGET) begin
            m_out[0] = m_mem[addr];
            m_ok[0]  = m_known[addr];
          end else begin
            model_write(addr, d);
          end
        end
      endcase
    end

    step++;
    e.step  = step;
    e.idx   = m_idx;
    e.st    = st;
    e.o     = m_out;
    e.known = m_ok;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("status", e.step, int'(status), e.st);
      check("index", e.step, int'(index), e.idx);
      if (e.known[0]) check("out", e.step, int'(out), int'(e.o[0]));
      if (e.known[1]) check("out1", e.step, int'(out1), int'(e.o[1]));
      if (e.known[2]) check("out2", e.step, int'(out2), int'(e.o[2]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MAX; i++) m_known[i] = 1'b0;

    // reset, then basic LIFO behaviour
    issue(NONE, 0, 0, 0, 0, 0, 1);
    issue(POP, 0, 0, 0, 0, 0, 0);          // UNDERFLOW at empty
    issue(PUSH, 8'd0, 0, 0, 0, 0, 0);      // NONE
    issue(PUSH, 8'd1, 0, 0, 0, 0, 0);      // NONE
    issue(PUSH, 8'd2, 0, 0, 0, 0, 0);      // FULL, 2/1/0
    issue(PUSH, 8'd3, 0, 0, 0, 0, 0);      // OVERFLOW
    issue(POP, 0, 0, 0, 0, 0, 0);          // NONE out=1
    issue(POP, 0, 0, 0, 0, 0, 0);          // NONE out=0
    issue(POP, 0, 0, 0, 0, 0, 0);          // EMPTY

    // replace and reset holding outputs
    issue(REPLACE, 8'd7, 0, 0, 0, 0, 0);   // UNDERFLOW
    issue(PUSH, 8'd5, 0, 0, 0, 0, 0);
    issue(REPLACE, 8'd6, 0, 0, 0, 0, 0);   // out=6 NONE
    issue(PUSH, 8'd9, 0, 0, 0, 0, 1);      // reset: index 0 EMPTY, out still 6

    // frame protection, limit 1
    issue(NONE, 0, 0, 1, 0, 0, 0);         // UNDERFLOW
    issue(PUSH, 8'd8, 0, 1, 0, 0, 0);      // EMPTY idx1
    issue(PUSH, 8'd9, 0, 1, 0, 0, 0);      // NONE idx2
    issue(IRST, 0, 1, 1, 0, 0, 0);         // EMPTY idx1 out=9
    issue(POP, 0, 0, 1, 0, 0, 0);          // UNDERFLOW
    issue(NONE, 0, 0, 0, 0, 0, 0);         // NONE out=8

    // index reset and push
    issue(IRST, 0, 0, 0, 0, 0, 0);
    issue(IRSTP, 8'h0a, 0, 2, 0, 0, 0);    // UNDERFLOW out=0a idx1
    issue(IRST, 0, 0, 0, 0, 0, 0);
    issue(IRSTP, 8'h0b, 0, 0, 0, 0, 0);    // NONE out=0b idx1

    // frame slot access
    issue(USET, 8'h0c, 0, 1, 0, 0, 0);     // BAD_OFFSET
    issue(USET, 8'h0c, 0, 1, 1, 0, 0);     // NONE
    issue(NONE, 0, 0, 1, 1, 0, 0);         // EMPTY
    issue(PUSH, 8'h0d, 0, 1, 1, 0, 0);     // out=0d idx2
    issue(UGET, 0, 0, 1, 1, 0, 0);         // out=0c NONE
    issue(UGET, 0, 1, 1, 1, 0, 0);         // BAD_OFFSET
    issue(IRSTP, 8'h55, 3, 0, 0, 0, 0);    // OVERFLOW, idx unchanged

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int ulim;
      ulim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      issue(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)),
            ulim, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0));
    end

    // let the monitor drain the scoreboard, bounded
    for (int c = 0; c < 4 && sb.size() > 0; c++) @(posedge clk);
    #2;
    check("drain", step, sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
